reg_scoreboard: RTL
===================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have parameter MAX_PEND, default 3, giving the maximum in-flight writes tracked per register; legal range 1..3, held in a 2-bit counter.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port Issue, input, 1 bit: the decode stage requests to advance an instruction this cycle.
REQ-005 The block SHALL have port IssueWrite, input, 1 bit: the issuing instruction writes a GPR.
REQ-006 The block SHALL have port IssueWA, input, 5 bits: the destination GPR of the issuing instruction.
REQ-007 The block SHALL have ports RA1 and RA2, input, 5 bits each: the source GPRs read by decode.
REQ-008 The block SHALL have ports Use1 and Use2, input, 1 bit each: RA1 and RA2 are actually consumed.
REQ-009 The block SHALL have port Retire, input, 1 bit: writeback asserts RegWrite this cycle.
REQ-010 The block SHALL have port RetireWA, input, 5 bits: the writeback destination GPR.
REQ-011 The block SHALL have port Stall, output, 1 bit: decode SHALL NOT advance.
REQ-012 The block SHALL have port InFlight, output, 7 bits: total pending GPR writes, registered.
REQ-013 The block SHALL have port Error, output, 1 bit: sticky protocol-violation flag, registered.

Function
REQ-014 The block SHALL hold a per-register pending counter pend[r] for r=1..31; pend[0] SHALL read as 0 permanently.
REQ-015 Stall SHALL be combinational from current state and inputs: (Use1 & pend[RA1]!=0) | (Use2 & pend[RA2]!=0) | (IssueWrite & IssueWA!=0 & pend[IssueWA]==MAX_PEND).
REQ-016 A same-cycle Retire SHALL NOT mask Stall; because the register file commits on the edge, Stall SHALL drop on the cycle after the last retire.
REQ-017 An issue SHALL be accepted only when Issue=1 and Stall=0; if Issue=1 while Stall=1, the issue SHALL have no state effect.
REQ-018 An accepted issue with IssueWrite=1 and IssueWA!=0 SHALL increment pend[IssueWA] and InFlight at the next edge.
REQ-019 Retire=1 with RetireWA!=0 and pend[RetireWA]!=0 SHALL decrement pend[RetireWA] and InFlight at the next edge.
REQ-020 Retire=1 with RetireWA!=0 and pend[RetireWA]==0 SHALL leave all counters unchanged and set Error=1.
REQ-021 An accepted issue and a valid retire to the same register in the same cycle SHALL leave that register's counter and InFlight unchanged.
REQ-022 An accepted issue and a valid retire to different registers SHALL update both counters, with InFlight unchanged.
REQ-023 Writes targeting register 0, on either the issue or the retire side, SHALL be ignored entirely, with no count change and no Error.
REQ-024 InFlight SHALL always equal the sum of pend[1..31], with a maximum of 31*MAX_PEND=93; it SHALL never wrap.
REQ-025 Once set, Error SHALL remain 1 until Reset.

Reset
REQ-026 Reset=1 SHALL immediately, without waiting for Clock, clear all pend[] entries, InFlight and Error to 0.
REQ-027 During and after reset, Stall SHALL follow REQ-015 against zeroed state, so Stall=0 while counters are zero.
REQ-028 Reset asserted mid-operation SHALL discard all pending state; retires arriving after reset for pre-reset issues SHALL set Error.

Verification
REQ-029 The bench SHALL cover: after reset, issue write $5 (accepted), then the next cycle Use1=1 with RA1=5 -> Stall=1 and InFlight=1; Retire to $5 -> Stall=1 in that cycle, Stall=0 in the following cycle, and InFlight=0.
REQ-030 The bench SHALL cover: issue $8 three times in consecutive cycles -> pend[8]=3; a fourth issue to $8 -> Stall=1, no increment, and InFlight=3.
REQ-031 The bench SHALL cover: with pend[9]=1, a simultaneous accepted issue $9 and Retire $9 -> pend[9] stays 1, InFlight unchanged, and Error=0.
REQ-032 The bench SHALL cover: Retire $12 with pend[12]=0 -> Error=1, counters unchanged; Error stays 1 over 10 further cycles.
REQ-033 The bench SHALL cover: issue to $0 and Retire to $0 with Use1=1 and RA1=0 -> Stall=0, InFlight=0, and Error=0.
REQ-034 The bench SHALL cover: with InFlight=4, Reset asserted between clock edges -> InFlight=0 and Error=0 before the next edge.

Source files
------------

// File: rtl/reg_scoreboard.sv
// GPR write scoreboard: tracks in-flight writes per register and stalls decode
// on read-after-write hazards or when a register's pending count is saturated.
module reg_scoreboard #(
  parameter int unsigned MAX_PEND = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Issue,
  input  logic       IssueWrite,
  input  logic [4:0] IssueWA,
  input  logic [4:0] RA1,
  input  logic [4:0] RA2,
  input  logic       Use1,
  input  logic       Use2,
  input  logic       Retire,
  input  logic [4:0] RetireWA,
  output logic       Stall,
  output logic [6:0] InFlight,
  output logic       Error
);

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = 2;
  localparam int unsigned IFW  = 7;
  localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PEND);

  logic [CW-1:0]  pend   [NREG];
  logic [CW-1:0]  pend_d [NREG];
  logic [IFW-1:0] in_flight_d;

  logic [CW-1:0] pend_ra1;
  logic [CW-1:0] pend_ra2;
  logic [CW-1:0] pend_iwa;
  logic [CW-1:0] pend_rwa;

  logic issue_ok;
  logic inc;
  logic ret_valid;
  logic dec;
  logic ret_err;

  // Register 0 is hardwired: its count always reads as zero.
  assign pend_ra1 = (RA1      == '0) ? '0 : pend[RA1];
  assign pend_ra2 = (RA2      == '0) ? '0 : pend[RA2];
  assign pend_iwa = (IssueWA  == '0) ? '0 : pend[IssueWA];
  assign pend_rwa = (RetireWA == '0) ? '0 : pend[RetireWA];

  // Same-cycle retire does not unmask: the regfile only commits on the edge.
  assign Stall = (Use1 && (pend_ra1 != '0))
               | (Use2 && (pend_ra2 != '0))
               | (IssueWrite && (IssueWA != '0) && (pend_iwa == PEND_MAX));

  assign issue_ok  = Issue && !Stall;
  assign inc       = issue_ok && IssueWrite && (IssueWA != '0);
  assign ret_valid = Retire && (RetireWA != '0);
  assign dec       = ret_valid && (pend_rwa != '0);
  assign ret_err   = ret_valid && (pend_rwa == '0);

  // Next-state counters; an issue and retire to one register cancel out.
  always_comb begin
    pend_d[0]   = '0;
    in_flight_d = InFlight;
    for (int r = 1; r < NREG; r++) begin
      pend_d[r] = pend[r];
      if (inc && (IssueWA == AW'(r))) pend_d[r] = pend_d[r] + CW'(1);
      if (dec && (RetireWA == AW'(r))) pend_d[r] = pend_d[r] - CW'(1);
    end
    if (inc && !dec) in_flight_d = InFlight + IFW'(1);
    else if (dec && !inc) in_flight_d = InFlight - IFW'(1);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
      InFlight <= '0;
      Error    <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) pend[r] <= pend_d[r];
      InFlight <= in_flight_d;
      Error    <= Error | ret_err;
    end
  end

endmodule
